// File: rtl/bellek_erisim_birimi.sv
// -----------------------------------------------------------------------------
// bellek_erisim_birimi
// Memory stage of the core. Accepts one load/store micro-op at a time, drives
// the bib_istek_* request port of veri_yolu_birimi, lane-aligns store data and
// builds the byte mask, and on loads waits for the returned word, extracts the
// addressed lane and sign/zero-extends it. The pipeline is held (giris_hazir_o
// low) until the access retires with a one-cycle tamam_o pulse.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   giris_*                 micro-op handshake and fields (yaz, boyut,
//                           isaretsiz, adres, veri, hedef)
//   bib_istek_*, bib_veri_o request to veri_yolu_birimi (valid, yaz, oku,
//                           adres, maske, lane-aligned store data)
//   bellek_hazir_i          bus accepts the request
//   bellek_veri_i/gecerli_i load word and its valid strobe
//   tamam_o                 micro-op retired (1-cycle pulse)
//   sonuc_yaz_o/veri_o/hedef_o  register write-back with tamam_o
//   hizasiz_o               misaligned-access flag with tamam_o
//
// Build option
//   HIZASIZ_ISTISNA_EN : when defined, misaligned half/word ops issue no bus
//                        request and retire next cycle with hizasiz_o=1 and the
//                        faulting address on sonuc_veri_o. When undefined,
//                        hizasiz_o stays 0 and low address bits that do not fit
//                        the access size are ignored.
// -----------------------------------------------------------------------------
module bellek_erisim_birimi #(
    parameter int ADRES_BIT  = 32,
    parameter int VERI_BIT   = 32,
    parameter int YAZMAC_BIT = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  giris_gecerli_i,
    output logic                  giris_hazir_o,
    input  logic                  giris_yaz_i,
    input  logic [1:0]            giris_boyut_i,
    input  logic                  giris_isaretsiz_i,
    input  logic [ADRES_BIT-1:0]  giris_adres_i,
    input  logic [VERI_BIT-1:0]   giris_veri_i,
    input  logic [YAZMAC_BIT-1:0] giris_hedef_i,
    output logic                  bib_istek_gecerli_o,
    output logic                  bib_istek_yaz_o,
    output logic                  bib_istek_oku_o,
    output logic [ADRES_BIT-1:0]  bib_istek_adres_o,
    output logic [VERI_BIT-1:0]   bib_veri_o,
    output logic [VERI_BIT/8-1:0] bib_istek_maske_o,
    input  logic                  bellek_hazir_i,
    input  logic [VERI_BIT-1:0]   bellek_veri_i,
    input  logic                  bellek_gecerli_i,
    output logic                  tamam_o,
    output logic                  sonuc_yaz_o,
    output logic [VERI_BIT-1:0]   sonuc_veri_o,
    output logic [YAZMAC_BIT-1:0] sonuc_hedef_o,
    output logic                  hizasiz_o
);

    localparam int VERI_BYTE = VERI_BIT / 8;
    localparam logic [VERI_BYTE-1:0] MASKE_BYTE  = VERI_BYTE'(1);
    localparam logic [VERI_BYTE-1:0] MASKE_YARIM = VERI_BYTE'(3);

    typedef enum logic [1:0] {
        BOSTA,
        ISTEK,
        YANIT
    } durum_t;

    durum_t durum_q, durum_d;

    logic                  istek_gecerli_q, istek_gecerli_d;
    logic                  istek_yaz_q, istek_yaz_d;
    logic                  istek_oku_q, istek_oku_d;
    logic [ADRES_BIT-1:0]  adres_q, adres_d;
    logic [VERI_BIT-1:0]   veri_q, veri_d;
    logic [VERI_BYTE-1:0]  maske_q, maske_d;
    logic [1:0]            boyut_q, boyut_d;
    logic                  isaretsiz_q, isaretsiz_d;
    logic [YAZMAC_BIT-1:0] hedef_q, hedef_d;
    logic                  tamam_q, tamam_d;
    logic                  sonuc_yaz_q, sonuc_yaz_d;
    logic [VERI_BIT-1:0]   sonuc_veri_q, sonuc_veri_d;
    logic [YAZMAC_BIT-1:0] sonuc_hedef_q, sonuc_hedef_d;
    logic                  hizasiz_q, hizasiz_d;

    logic [VERI_BIT-1:0]   hizali_veri;
    logic [VERI_BYTE-1:0]  hizali_maske;
    logic [7:0]            kayik_byte;
    logic [15:0]           kayik_yarim;
    logic [VERI_BIT-1:0]   yuklenen;
    logic                  hizasiz_giris;

`ifdef HIZASIZ_ISTISNA_EN
    assign hizasiz_giris = ((giris_boyut_i == 2'b01) && giris_adres_i[0]) ||
                           (giris_boyut_i[1] && (giris_adres_i[1:0] != 2'b00));
`else
    assign hizasiz_giris = 1'b0;
`endif

    // Store lane alignment: replicate the low bytes across the word so the
    // mask alone selects which lane the bus actually writes.
    always_comb begin
        case (giris_boyut_i)
            2'b00: begin
                hizali_veri  = {VERI_BYTE{giris_veri_i[7:0]}};
                hizali_maske = MASKE_BYTE << giris_adres_i[1:0];
            end
            2'b01: begin
                hizali_veri  = {(VERI_BYTE/2){giris_veri_i[15:0]}};
                hizali_maske = MASKE_YARIM << {giris_adres_i[1], 1'b0};
            end
            default: begin
                hizali_veri  = giris_veri_i;
                hizali_maske = '1;
            end
        endcase
    end

    // Load lane extraction and extension, using the fields latched at accept.
    always_comb begin
        kayik_byte  = 8'(bellek_veri_i >> {adres_q[1:0], 3'b000});
        kayik_yarim = 16'(bellek_veri_i >> {adres_q[1], 4'b0000});
        case (boyut_q)
            2'b00:   yuklenen = {{(VERI_BIT-8){kayik_byte[7] & ~isaretsiz_q}}, kayik_byte};
            2'b01:   yuklenen = {{(VERI_BIT-16){kayik_yarim[15] & ~isaretsiz_q}}, kayik_yarim};
            default: yuklenen = bellek_veri_i;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q <= BOSTA;
        end else begin
            durum_q <= durum_d;
        end
    end

    always_comb begin
        durum_d         = durum_q;
        istek_gecerli_d = 1'b0;
        istek_yaz_d     = istek_yaz_q;
        istek_oku_d     = istek_oku_q;
        adres_d         = adres_q;
        veri_d          = veri_q;
        maske_d         = maske_q;
        boyut_d         = boyut_q;
        isaretsiz_d     = isaretsiz_q;
        hedef_d         = hedef_q;
        tamam_d         = 1'b0;
        sonuc_yaz_d     = 1'b0;
        hizasiz_d       = 1'b0;
        sonuc_veri_d    = sonuc_veri_q;
        sonuc_hedef_d   = sonuc_hedef_q;

        case (durum_q)
            BOSTA: begin
                if (giris_gecerli_i) begin
                    if (hizasiz_giris) begin
                        // Faulting op retires straight from idle; no request.
                        tamam_d       = 1'b1;
                        hizasiz_d     = 1'b1;
                        sonuc_veri_d  = VERI_BIT'(giris_adres_i);
                        sonuc_hedef_d = giris_hedef_i;
                    end else begin
                        durum_d         = ISTEK;
                        istek_gecerli_d = 1'b1;
                        istek_yaz_d     = giris_yaz_i;
                        istek_oku_d     = ~giris_yaz_i;
                        adres_d         = giris_adres_i;
                        veri_d          = hizali_veri;
                        maske_d         = hizali_maske;
                        boyut_d         = giris_boyut_i;
                        isaretsiz_d     = giris_isaretsiz_i;
                        hedef_d         = giris_hedef_i;
                    end
                end
            end
            ISTEK: begin
                istek_gecerli_d = 1'b1;
                if (bellek_hazir_i) begin
                    istek_gecerli_d = 1'b0;
                    istek_yaz_d     = 1'b0;
                    istek_oku_d     = 1'b0;
                    if (istek_yaz_q) begin
                        // Posted write: retire as soon as the bus takes it.
                        tamam_d       = 1'b1;
                        sonuc_veri_d  = '0;
                        sonuc_hedef_d = hedef_q;
                        durum_d       = BOSTA;
                    end else begin
                        durum_d = YANIT;
                    end
                end
            end
            YANIT: begin
                if (bellek_gecerli_i) begin
                    tamam_d       = 1'b1;
                    sonuc_yaz_d   = (hedef_q != '0);
                    sonuc_veri_d  = yuklenen;
                    sonuc_hedef_d = hedef_q;
                    durum_d       = BOSTA;
                end
            end
            default: durum_d = BOSTA;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            istek_gecerli_q <= 1'b0;
            istek_yaz_q     <= 1'b0;
            istek_oku_q     <= 1'b0;
            adres_q         <= '0;
            veri_q          <= '0;
            maske_q         <= '0;
            boyut_q         <= '0;
            isaretsiz_q     <= 1'b0;
            hedef_q         <= '0;
            tamam_q         <= 1'b0;
            sonuc_yaz_q     <= 1'b0;
            sonuc_veri_q    <= '0;
            sonuc_hedef_q   <= '0;
            hizasiz_q       <= 1'b0;
        end else begin
            istek_gecerli_q <= istek_gecerli_d;
            istek_yaz_q     <= istek_yaz_d;
            istek_oku_q     <= istek_oku_d;
            adres_q         <= adres_d;
            veri_q          <= veri_d;
            maske_q         <= maske_d;
            boyut_q         <= boyut_d;
            isaretsiz_q     <= isaretsiz_d;
            hedef_q         <= hedef_d;
            tamam_q         <= tamam_d;
            sonuc_yaz_q     <= sonuc_yaz_d;
            sonuc_veri_q    <= sonuc_veri_d;
            sonuc_hedef_q   <= sonuc_hedef_d;
            hizasiz_q       <= hizasiz_d;
        end
    end

    assign giris_hazir_o       = (durum_q == BOSTA);
    assign bib_istek_gecerli_o = istek_gecerli_q;
    assign bib_istek_yaz_o     = istek_yaz_q;
    assign bib_istek_oku_o     = istek_oku_q;
    assign bib_istek_adres_o   = adres_q;
    assign bib_veri_o          = veri_q;
    assign bib_istek_maske_o   = maske_q;
    assign tamam_o             = tamam_q;
    assign sonuc_yaz_o         = sonuc_yaz_q;
    assign sonuc_veri_o        = sonuc_veri_q;
    assign sonuc_hedef_o       = sonuc_hedef_q;
    assign hizasiz_o           = hizasiz_q;

endmodule

// File: tb/tb_bellek_erisim_birimi.sv
// -----------------------------------------------------------------------------
// tb_bellek_erisim_birimi
// Directed bench for bellek_erisim_birimi with a transaction-level model of
// expected bus requests and retirements, a bus responder, and a compare process
// sampling on the falling edge. Inputs change 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_bellek_erisim_birimi;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        giris_gecerli_i;
    logic        giris_hazir_o;
    logic        giris_yaz_i;
    logic [1:0]  giris_boyut_i;
    logic        giris_isaretsiz_i;
    logic [31:0] giris_adres_i;
    logic [31:0] giris_veri_i;
    logic [4:0]  giris_hedef_i;
    logic        bib_istek_gecerli_o;
    logic        bib_istek_yaz_o;
    logic        bib_istek_oku_o;
    logic [31:0] bib_istek_adres_o;
    logic [31:0] bib_veri_o;
    logic [3:0]  bib_istek_maske_o;
    logic        bellek_hazir_i;
    logic [31:0] bellek_veri_i;
    logic        bellek_gecerli_i;
    logic        tamam_o;
    logic        sonuc_yaz_o;
    logic [31:0] sonuc_veri_o;
    logic [4:0]  sonuc_hedef_o;
    logic        hizasiz_o;

    bellek_erisim_birimi #(
        .ADRES_BIT  (32),
        .VERI_BIT   (32),
        .YAZMAC_BIT (5)
    ) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .giris_gecerli_i     (giris_gecerli_i),
        .giris_hazir_o       (giris_hazir_o),
        .giris_yaz_i         (giris_yaz_i),
        .giris_boyut_i       (giris_boyut_i),
        .giris_isaretsiz_i   (giris_isaretsiz_i),
        .giris_adres_i       (giris_adres_i),
        .giris_veri_i        (giris_veri_i),
        .giris_hedef_i       (giris_hedef_i),
        .bib_istek_gecerli_o (bib_istek_gecerli_o),
        .bib_istek_yaz_o     (bib_istek_yaz_o),
        .bib_istek_oku_o     (bib_istek_oku_o),
        .bib_istek_adres_o   (bib_istek_adres_o),
        .bib_veri_o          (bib_veri_o),
        .bib_istek_maske_o   (bib_istek_maske_o),
        .bellek_hazir_i      (bellek_hazir_i),
        .bellek_veri_i       (bellek_veri_i),
        .bellek_gecerli_i    (bellek_gecerli_i),
        .tamam_o             (tamam_o),
        .sonuc_yaz_o         (sonuc_yaz_o),
        .sonuc_veri_o        (sonuc_veri_o),
        .sonuc_hedef_o       (sonuc_hedef_o),
        .hizasiz_o           (hizasiz_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        n_cmp++;
        if (gercek !== beklenen) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", ad, gercek, beklenen, $time);
        end
    endtask

    task automatic hata(input string ad);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: event not expected / not seen (t=%0t)", ad, $time);
    endtask

    // ---------------- model ----------------
    typedef struct {
        logic        yaz;
        logic [31:0] adres;
        logic [31:0] veri;
        logic [3:0]  maske;
    } istek_t;

    typedef struct {
        logic        yaz;
        logic        hiz;
        logic        veri_kontrol;
        logic [31:0] veri;
        logic [4:0]  hedef;
    } sonuc_t;

    istek_t istek_q[$];
    sonuc_t sonuc_q[$];

    function automatic logic [3:0] m_maske(input logic [1:0] b, input logic [31:0] a);
        if (b == 2'd0) return 4'(1 << (a % 4));
        if (b == 2'd1) return 4'(3 << (2 * ((a / 2) % 2)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_veri(input logic [1:0] b, input logic [31:0] d);
        int n;
        logic [31:0] r;
        n = (b == 2'd0) ? 1 : (b == 2'd1) ? 2 : 4;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_sonuc(input logic [1:0] b, input logic isz,
                                            input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        if (b == 2'd0) begin
            v = (w >> (8 * (a % 4))) & 32'hFF;
            if (!isz && v >= 128) v = v - 256;
        end else if (b == 2'd1) begin
            v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (!isz && v >= 32768) v = v - 65536;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic m_hizasiz(input logic [1:0] b, input logic [31:0] a);
        return (b == 2'd1 && (a % 2) != 0) || (b >= 2'd2 && (a % 4) != 0);
    endfunction

    task automatic model_ekle(input logic yaz, input logic [1:0] b, input logic isz,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [4:0] h, input logic [31:0] yanit);
        istek_t i;
        sonuc_t s;
`ifdef HIZASIZ_ISTISNA_EN
        if (m_hizasiz(b, a)) begin
            s.yaz = 1'b0; s.hiz = 1'b1; s.veri_kontrol = 1'b1; s.veri = a; s.hedef = h;
            sonuc_q.push_back(s);
            return;
        end
`endif
        i.yaz = yaz; i.adres = a; i.veri = m_veri(b, d); i.maske = m_maske(b, a);
        istek_q.push_back(i);
        s.yaz = !yaz && (h != 0);
        s.hiz = 1'b0;
        s.veri_kontrol = !yaz;
        s.veri = m_sonuc(b, isz, a, yanit);
        s.hedef = h;
        sonuc_q.push_back(s);
    endtask

    // ---------------- bus responder ----------------
    int          stall_left = 0;
    int          gecikme_n  = 1;
    int          resp_wait  = 0;
    logic [31:0] yanit_veri = '0;

    initial begin
        bellek_hazir_i   = 1'b1;
        bellek_gecerli_i = 1'b0;
        bellek_veri_i    = '0;
        forever begin
            @(posedge clk_i);
            #1;
            bellek_gecerli_i = 1'b0;
            bellek_veri_i    = $urandom;
            if (resp_wait > 0) begin
                resp_wait--;
                if (resp_wait == 0) begin
                    bellek_gecerli_i = 1'b1;
                    bellek_veri_i    = yanit_veri;
                end
            end
            if (bib_istek_gecerli_o && stall_left > 0) begin
                bellek_hazir_i = 1'b0;
                stall_left--;
            end else begin
                bellek_hazir_i = 1'b1;
            end
            if (bib_istek_gecerli_o && bellek_hazir_i && bib_istek_oku_o) resp_wait = gecikme_n;
        end
    end

    // ---------------- compare process ----------------
    int          kabul_sayac  = 0;
    int          tamam_sayac  = 0;
    int          son_tamam_cyc = 0;
    logic [31:0] son_istek_veri;
    logic [3:0]  son_istek_maske;
    logic [31:0] son_sonuc_veri;
    logic        son_sonuc_yaz;
    logic        son_hizasiz;

    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (bib_istek_gecerli_o) begin
                    chk("istek_sirasinda_hazir", giris_hazir_o, 0);
                    if (istek_q.size() == 0) begin
                        hata("beklenmeyen_istek");
                    end else begin
                        chk("istek_yaz", bib_istek_yaz_o, istek_q[0].yaz);
                        chk("istek_oku", bib_istek_oku_o, !istek_q[0].yaz);
                        chk("istek_adres", bib_istek_adres_o, istek_q[0].adres);
                        if (istek_q[0].yaz) begin
                            chk("istek_veri", bib_veri_o, istek_q[0].veri);
                            chk("istek_maske", bib_istek_maske_o, istek_q[0].maske);
                        end
                        if (bellek_hazir_i) begin
                            son_istek_veri  = bib_veri_o;
                            son_istek_maske = bib_istek_maske_o;
                            kabul_sayac++;
                            void'(istek_q.pop_front());
                        end
                    end
                end
                if (tamam_o) begin
                    tamam_sayac++;
                    son_tamam_cyc  = cyc;
                    son_sonuc_veri = sonuc_veri_o;
                    son_sonuc_yaz  = sonuc_yaz_o;
                    son_hizasiz    = hizasiz_o;
                    if (sonuc_q.size() == 0) begin
                        hata("beklenmeyen_tamam");
                    end else begin
                        chk("sonuc_yaz", sonuc_yaz_o, sonuc_q[0].yaz);
                        chk("hizasiz", hizasiz_o, sonuc_q[0].hiz);
                        if (sonuc_q[0].veri_kontrol) begin
                            chk("sonuc_veri", sonuc_veri_o, sonuc_q[0].veri);
                            if (!sonuc_q[0].hiz) chk("sonuc_hedef", sonuc_hedef_o, sonuc_q[0].hedef);
                        end
                        void'(sonuc_q.pop_front());
                    end
                end else begin
                    chk("sonuc_yaz_bosta", sonuc_yaz_o, 0);
                    chk("hizasiz_bosta", hizasiz_o, 0);
                end
            end
        end
    end

    // ---------------- driver ----------------
    int kabul_cyc = 0;

    task automatic gonder(input logic yaz, input logic [1:0] b, input logic isz,
                          input logic [31:0] a, input logic [31:0] d, input logic [4:0] h,
                          input int stall, input int gecikme, input logic [31:0] yanit);
        int k;
        stall_left = stall;
        gecikme_n  = gecikme;
        yanit_veri = yanit;
        model_ekle(yaz, b, isz, a, d, h, yanit);
        giris_yaz_i       = yaz;
        giris_boyut_i     = b;
        giris_isaretsiz_i = isz;
        giris_adres_i     = a;
        giris_veri_i      = d;
        giris_hedef_i     = h;
        giris_gecerli_i   = 1'b1;
        for (k = 0; k < 50; k++) begin
            if (giris_hazir_o) break;
            @(negedge clk_i);
        end
        if (k == 50) hata("giris_kabul_zaman_asimi");
        @(posedge clk_i);
        #1;
        kabul_cyc         = cyc - 1;
        giris_gecerli_i   = 1'b0;
        giris_yaz_i       = 1'($urandom);
        giris_boyut_i     = 2'($urandom);
        giris_isaretsiz_i = 1'($urandom);
        giris_adres_i     = $urandom;
        giris_veri_i      = $urandom;
        giris_hedef_i     = 5'($urandom);
    endtask

    task automatic bekle_tamam(output int lat);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk_i);
            if (tamam_o) break;
        end
        if (k == 200) hata("tamam_zaman_asimi");
        #1;
        lat = son_tamam_cyc - kabul_cyc;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        int lat;
        int onceki;

        rst_i = 1'b1;
        giris_gecerli_i = 1'b0; giris_yaz_i = 1'b0; giris_boyut_i = '0; giris_isaretsiz_i = 1'b0;
        giris_adres_i = '0; giris_veri_i = '0; giris_hedef_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_giris_hazir", giris_hazir_o, 1);
        chk("reset_tamam", tamam_o, 0);
        chk("reset_istek_gecerli", bib_istek_gecerli_o, 0);
        chk("reset_maske", bib_istek_maske_o, 0);
        chk("reset_sonuc_veri", sonuc_veri_o, 0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // 1: SB 0xAB @0x1003
        gonder(1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_00AB, 5'd3, 0, 1, '0);
        bekle_tamam(lat);
        chk("t1_veri", son_istek_veri, 32'hABAB_ABAB);
        chk("t1_maske", son_istek_maske, 4'b1000);
        chk("t1_sonuc_yaz", son_sonuc_yaz, 0);
        chk("t1_gecikme", lat, 2);

        // SH @0x0002 -> upper half lanes
        gonder(1'b1, 2'd1, 1'b0, 32'h0002, 32'h1234_ABCD, 5'd0, 0, 1, '0);
        bekle_tamam(lat);
        chk("sh_veri", son_istek_veri, 32'hABCD_ABCD);
        chk("sh_maske", son_istek_maske, 4'b1100);

        // 2: LH / LHU @0x2002, response after 3 cycles
        gonder(1'b0, 2'd1, 1'b0, 32'h2002, '0, 5'd5, 0, 3, 32'h8001_1234);
        bekle_tamam(lat);
        chk("t2_lh_veri", son_sonuc_veri, 32'hFFFF_8001);
        chk("t2_lh_yaz", son_sonuc_yaz, 1);
        chk("t2_gecikme", lat, 5);
        gonder(1'b0, 2'd1, 1'b1, 32'h2002, '0, 5'd6, 0, 3, 32'h8001_1234);
        bekle_tamam(lat);
        chk("t2_lhu_veri", son_sonuc_veri, 32'h0000_8001);

        // further load extraction vectors
        gonder(1'b0, 2'd1, 1'b0, 32'h2000, '0, 5'd7, 0, 1, 32'h8001_1234);
        bekle_tamam(lat);
        chk("lh_alt_veri", son_sonuc_veri, 32'h0000_1234);
        gonder(1'b0, 2'd0, 1'b0, 32'h2001, '0, 5'd8, 0, 2, 32'h1234_5680);
        bekle_tamam(lat);
        chk("lb_pozitif", son_sonuc_veri, 32'h0000_0056);
        gonder(1'b0, 2'd0, 1'b0, 32'h2000, '0, 5'd8, 0, 1, 32'h1234_5680);
        bekle_tamam(lat);
        chk("lb_negatif", son_sonuc_veri, 32'hFFFF_FF80);
        gonder(1'b0, 2'd0, 1'b1, 32'h2000, '0, 5'd8, 0, 1, 32'h1234_5680);
        bekle_tamam(lat);
        chk("lbu", son_sonuc_veri, 32'h0000_0080);
        gonder(1'b0, 2'd0, 1'b1, 32'h2003, '0, 5'd9, 0, 1, 32'h1234_5680);
        bekle_tamam(lat);
        chk("lbu_ust", son_sonuc_veri, 32'h0000_0012);

        // 3: SW with bus busy for 5 cycles
        onceki = kabul_sayac;
        gonder(1'b1, 2'd2, 1'b0, 32'h3000, 32'hDEAD_BEEF, 5'd0, 5, 1, '0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("t3_hazir_dusuk", giris_hazir_o, 0);
        end
        bekle_tamam(lat);
        chk("t3_tek_kabul", kabul_sayac - onceki, 1);
        chk("t3_gecikme", lat, 7);

        // 4: reset pulsed while waiting for the load word; stray response later
        gonder(1'b0, 2'd2, 1'b0, 32'h4000, '0, 5'd9, 0, 8, 32'h5555_AAAA);
        @(posedge clk_i); #1;
        chk("t4_yanit_istek_yok", bib_istek_gecerli_o, 0);
        chk("t4_yanit_hazir", giris_hazir_o, 0);
        rst_i = 1'b1;
        istek_q.delete();
        sonuc_q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        chk("t4_reset_hazir", giris_hazir_o, 1);
        chk("t4_reset_tamam", tamam_o, 0);
        chk("t4_reset_sonuc_veri", sonuc_veri_o, 0);
        chk("t4_reset_adres", bib_istek_adres_o, 0);
        rst_i = 1'b0;
        onceki = tamam_sayac;
        repeat (12) @(posedge clk_i);
        #1;
        chk("t4_geç_yanit_yok_sayildi", tamam_sayac - onceki, 0);
        chk("t4_son_hazir", giris_hazir_o, 1);

        // 5: LW @0x1002
        onceki = kabul_sayac;
        gonder(1'b0, 2'd2, 1'b0, 32'h1002, '0, 5'd4, 0, 1, 32'h1122_3344);
        bekle_tamam(lat);
`ifdef HIZASIZ_ISTISNA_EN
        chk("t5_istek_yok", kabul_sayac - onceki, 0);
        chk("t5_hizasiz", son_hizasiz, 1);
        chk("t5_adres", son_sonuc_veri, 32'h0000_1002);
        chk("t5_gecikme", lat, 1);
`else
        chk("t5_istek", kabul_sayac - onceki, 1);
        chk("t5_maske", son_istek_maske, 4'b1111);
        chk("t5_veri", son_sonuc_veri, 32'h1122_3344);
        chk("t5_hizasiz", son_hizasiz, 0);
`endif

        // 6: LB to x0, SW issued in the tamam_o cycle
        gonder(1'b0, 2'd0, 1'b0, 32'h0010, '0, 5'd0, 0, 2, 32'h0000_00FF);
        bekle_tamam(lat);
        chk("t6_x0_yaz", son_sonuc_yaz, 0);
        chk("t6_x0_veri", son_sonuc_veri, 32'hFFFF_FFFF);
        onceki = son_tamam_cyc;
        gonder(1'b1, 2'd2, 1'b0, 32'h0020, 32'hCAFE_F00D, 5'd0, 0, 1, '0);
        chk("t6_ayni_cevrim_kabul", kabul_cyc, onceki);
        chk("t6_istek_gecerli", bib_istek_gecerli_o, 1);
        chk("t6_hazir_dusuk", giris_hazir_o, 0);
        bekle_tamam(lat);
        chk("t6_sw_gecikme", lat, 2);

        repeat (3) @(posedge clk_i);
        #1;
        chk("son_kuyruk_istek", istek_q.size(), 0);
        chk("son_kuyruk_sonuc", sonuc_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
